fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, meaning the PC value loaded on reset (bits [1:0] ignored, treated as 0).
REQ-002 SHALL have parameter DEPTH, default 2, meaning instruction buffer entries (legal 2..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  32  fetch address, word aligned.
REQ-007 SHALL have port imem_ready  input  1  memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid.
REQ-009 SHALL have port imem_rdata  input  32  instruction word returned.
REQ-010 SHALL have port redirect  input  1  control transfer (jalr/branch), flush and restart.
REQ-011 SHALL have port redirect_pc  input  32  new fetch PC.
REQ-012 SHALL have port inst_valid  output  1  buffer head holds a valid instruction.
REQ-013 SHALL have port inst_ready  input  1  decode stage consumes the head this cycle.
REQ-014 SHALL have port inst  output  32  head instruction word.
REQ-015 SHALL have port inst_pc  output  32  PC of head instruction.
REQ-016 SHALL have port op  output  7  inst[6:0], opcode field for the main decoder.
REQ-017 SHALL have port funct3  output  3  inst[14:12], function field for the main decoder.

Function
REQ-018 SHALL implement FSM states REQ (imem_req high), WAIT (one request outstanding), DROP (outstanding response to discard); at most one request outstanding.
REQ-019 SHALL assert imem_req in REQ only when buffer count < DEPTH; imem_addr = fetch PC.
REQ-020 SHALL treat a request as accepted when imem_req && imem_ready; then PC <= PC + 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and REQ -> WAIT.
REQ-021 SHALL, in WAIT with imem_rvalid, push {PC of request, imem_rdata} into the buffer and return to REQ; response latency is >= 1 cycle after acceptance.
REQ-022 SHALL ignore imem_rvalid in REQ state.
REQ-023 SHALL present the buffer head on inst/inst_pc/op/funct3 combinationally with inst_valid = (count != 0); outputs hold stable while inst_valid && !inst_ready.
REQ-024 SHALL pop the head when inst_valid && inst_ready; push and pop in the same cycle keep count unchanged.
REQ-025 SHALL never push when full (guaranteed by REQ-019) and never pop when empty.
REQ-026 SHALL on redirect: empty the buffer, load PC <= {redirect_pc[31:2], 2'b00}, suppress any pop/push that cycle, and deassert imem_req that cycle.
REQ-027 SHALL on redirect in WAIT without imem_rvalid go to DROP; in WAIT with imem_rvalid same cycle, discard the data and go to REQ; in REQ or DROP stay/go to REQ or DROP respectively, with a request accepted... none issued that cycle.
REQ-028 SHALL in DROP discard the response on imem_rvalid and go to REQ; a further redirect in DROP only updates PC.
REQ-029 SHALL resume fetching from the redirected PC the cycle after redirect (REQ state) or after the dropped response.

Reset
REQ-030 SHALL on rst: PC <= PC_RESET, state <= REQ, buffer count <= 0, read/write pointers <= 0.
REQ-031 SHALL during rst drive imem_req = 0, inst_valid = 0; inst, inst_pc, op, funct3 values are don't-care while inst_valid = 0.
REQ-032 SHALL let rst override redirect and all handshakes; memory is reset by the same rst, so no pre-reset response arrives afterwards.

Verification
REQ-033 Reset then imem_ready=1, rvalid 1 cycle after each accept, inst_ready=1 -> addresses 0x0,0x4,0x8 requested; inst_pc sequence 0x0,0x4,0x8 with matching inst.
REQ-034 imem_rdata=32'h0000_0033 at PC 0 -> op=7'b0110011, funct3=3'b000, inst_valid=1.
REQ-035 inst_ready=0 for 10 cycles, DEPTH=2 -> exactly 2 entries buffered, imem_req low afterwards, head stays PC 0x0; release -> pops 0x0,0x4 in order, fetching resumes at 0x8.
REQ-036 Redirect to 32'h0000_0103 while in WAIT -> pending response dropped, buffer empty, next imem_addr = 0x100, first inst_pc = 0x100.
REQ-037 Redirect in same cycle as imem_rvalid and inst_ready -> no pop, data discarded, inst_valid=0 next cycle.
REQ-038 PC_RESET=32'hFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 (wrap).

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-aligned fetch at a time, buffers returned
// words with their PCs in a small FIFO, and flushes/restarts on a control redirect.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_e         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    req_pc_q, req_pc_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  entry_t         buf_q [DEPTH];
  entry_t         head;
  logic           full, accept, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full       = (count_q == CW'(DEPTH));
  assign imem_req   = !rst && !redirect && (state_q == S_REQ) && !full;
  assign imem_addr  = pc_q;
  assign accept     = imem_req && imem_ready;
  assign push       = !redirect && (state_q == S_WAIT) && imem_rvalid;
  assign inst_valid = !rst && (count_q != '0);
  assign pop        = inst_valid && inst_ready && !redirect;

  assign head    = buf_q[rd_ptr_q];
  assign inst    = head.word;
  assign inst_pc = head.pc;
  assign op      = head.word[6:0];
  assign funct3  = head.word[14:12];

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      pc_d     = redirect_pc & ~32'h3;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      // An outstanding request whose response has not yet arrived must be drained.
      if (state_q == S_WAIT && !imem_rvalid)
        state_d = S_DROP;
      else if (state_q != S_REQ && imem_rvalid)
        state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (accept) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT, S_DROP: begin
          if (imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)
        count_d = count_q + CW'(1);
      else if (pop && !push)
        count_d = count_q - CW'(1);
    end
  end

  // NOTE: state uses non-blocking assignments; the reset here is synchronous, so it
  // lives inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= PC_RESET & ~32'h3;
      req_pc_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= '{pc: req_pc_q, word: imem_rdata};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and popped (pc, word) pairs
// are queued by the stimulus and consumed by an independent monitor.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req, imem_ready, imem_rvalid = 1'b0, redirect, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata = '0, redirect_pc, inst, inst_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;

  logic        w_rst, w_imem_req, w_imem_ready, w_imem_rvalid = 1'b0, w_inst_valid, w_inst_ready;
  logic [31:0] w_imem_addr, w_imem_rdata = '0, w_inst, w_inst_pc;
  logic [6:0]  w_op;
  logic [2:0]  w_funct3;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .op(op), .funct3(funct3)
  );

  fetch_unit #(.PC_RESET(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clk(clk), .rst(w_rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(w_imem_ready), .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
    .redirect(1'b0), .redirect_pc(32'h0), .inst_valid(w_inst_valid),
    .inst_ready(w_inst_ready), .inst(w_inst), .inst_pc(w_inst_pc), .op(w_op), .funct3(w_funct3)
  );

  int checks = 0;
  int errors = 0;
  int n_acc = 0, n_pop = 0, w_n_acc = 0;
  int mem_lat = 1;

  logic [31:0] exp_addr[$], exp_pc[$], w_exp_addr[$], w_exp_pc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[5:2], 12'h033};
  endfunction

  task automatic expect_stream(input logic [31:0] start);
    exp_addr.delete();
    exp_pc.delete();
    for (int i = 0; i < 16; i++) begin
      exp_addr.push_back(start + 32'(4 * i));
      exp_pc.push_back(start + 32'(4 * i));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Instruction memory for the main DUT: one outstanding request, response mem_lat cycles later.
  logic        pending = 1'b0;
  int          cnt = 0;
  logic [31:0] p_addr = '0;
  initial forever begin
    @(negedge clk);
    if (pending && cnt > 0) cnt--;
    imem_rvalid = pending && (cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(p_addr) : 32'h0;
    #4;
    if (imem_rvalid) pending = 1'b0;
    if (imem_req && imem_ready) begin
      pending = 1'b1;
      cnt     = mem_lat;
      p_addr  = imem_addr;
    end
    if (rst) pending = 1'b0;
  end

  // Instruction memory for the wrap instance: fixed one-cycle latency.
  logic        w_pend = 1'b0;
  logic [31:0] w_paddr = '0;
  initial forever begin
    @(negedge clk);
    w_imem_rvalid = w_pend;
    w_imem_rdata  = mem_word(w_paddr);
    #4;
    w_pend = w_imem_req && w_imem_ready;
    if (w_pend) w_paddr = w_imem_addr;
  end

  // Monitor: pops expectations whenever a request is accepted or an instruction is consumed.
  initial forever begin
    logic [31:0] e, word;
    @(negedge clk);
    #4;
    if (imem_req && imem_ready) begin
      n_acc++;
      if (exp_addr.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_addr: got %h expected no request", imem_addr);
      end else check("req_addr", imem_addr, exp_addr.pop_front());
    end
    if (inst_valid && inst_ready && !redirect) begin
      n_pop++;
      if (exp_pc.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_pc: got %h expected no pop", inst_pc);
      end else begin
        e    = exp_pc.pop_front();
        word = mem_word(e);
        check("pop_pc", inst_pc, e);
        check("pop_inst", inst, word);
        check("pop_op", op, word[6:0]);
        check("pop_funct3", funct3, word[14:12]);
      end
    end
    if (w_imem_req && w_imem_ready) begin
      w_n_acc++;
      if (w_exp_addr.size() == 0) begin
        checks++; errors++;
        $display("FAIL wrap_req_addr: got %h expected no request", w_imem_addr);
      end else check("wrap_req_addr", w_imem_addr, w_exp_addr.pop_front());
    end
    if (w_inst_valid && w_inst_ready) begin
      if (w_exp_pc.size() == 0) begin
        checks++; errors++;
        $display("FAIL wrap_pop_pc: got %h expected no pop", w_inst_pc);
      end else begin
        e = w_exp_pc.pop_front();
        check("wrap_pop_pc", w_inst_pc, e);
        check("wrap_pop_inst", w_inst, mem_word(e));
      end
    end
  end

  task automatic do_reset();
    rst        = 1'b1;
    imem_ready = 1'b0;
    inst_ready = 1'b0;
    redirect   = 1'b0;
    mem_lat    = 1;
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    tick();
    tick();
    n_acc = 0;
    n_pop = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; w_rst = 1'b1; imem_ready = 1'b0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; w_imem_ready = 1'b1; w_inst_ready = 1'b1;
    tick();
    tick();
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_wrap_imem_req", w_imem_req, 1'b0);

    // Streaming fetch from reset, plus the wrapping instance running alongside.
    expect_stream(32'h0);
    for (int i = 0; i < 64; i++) begin
      w_exp_addr.push_back(32'hFFFF_FFF8 + 32'(4 * i));
      w_exp_pc.push_back(32'hFFFF_FFF8 + 32'(4 * i));
    end
    n_acc = 0; n_pop = 0;
    rst = 1'b0; w_rst = 1'b0; imem_ready = 1'b1; inst_ready = 1'b1;
    #1;
    check("p1_first_addr", imem_addr, 32'h0);
    check("p1_first_req", imem_req, 1'b1);
    check("wrap_addr0", w_imem_addr, 32'hFFFF_FFF8);
    tick();                                   // C1
    tick();                                   // C2
    check("p1_head_valid", inst_valid, 1'b1);
    check("p1_head_pc", inst_pc, 32'h0);
    check("p1_head_inst", inst, 32'h0000_0033);
    check("p1_op", op, 7'b0110011);
    check("p1_funct3", funct3, 3'b000);
    check("wrap_addr1", w_imem_addr, 32'hFFFF_FFFC);
    tick();                                   // C3
    tick();                                   // C4
    check("wrap_addr2", w_imem_addr, 32'h0);
    check("wrap_req2", w_imem_req, 1'b1);
    repeat (4) tick();                        // C8
    check("p1_accepts", n_acc, 4);
    check("p1_pops", n_pop, 3);
    do_reset();

    // Decode stalled: buffer fills to DEPTH, then drains in order.
    expect_stream(32'h0);
    rst = 1'b0; imem_ready = 1'b1; inst_ready = 1'b0;
    repeat (5) tick();                        // C5
    check("p2_head_pc_mid", inst_pc, 32'h0);
    repeat (4) tick();                        // C9
    check("p2_req_low_full", imem_req, 1'b0);
    check("p2_head_valid", inst_valid, 1'b1);
    check("p2_head_pc", inst_pc, 32'h0);
    check("p2_head_inst", inst, 32'h0000_0033);
    check("p2_accepts_full", n_acc, 2);
    check("p2_no_pops", n_pop, 0);
    tick();                                   // C10
    inst_ready = 1'b1;
    #1;
    check("p2_req_low_still_full", imem_req, 1'b0);
    tick();                                   // C11
    check("p2_resume_req", imem_req, 1'b1);
    check("p2_resume_addr", imem_addr, 32'h8);
    repeat (3) tick();                        // C14
    check("p2_accepts", n_acc, 4);
    check("p2_pops", n_pop, 3);
    do_reset();

    // Redirect while a slow response is outstanding.
    expect_stream(32'h0);
    mem_lat = 3;
    rst = 1'b0; imem_ready = 1'b1; inst_ready = 1'b1;
    tick();                                   // C1: in WAIT
    expect_stream(32'h100);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    check("p3_req_low_redirect", imem_req, 1'b0);
    tick();                                   // C2: DROP
    redirect = 1'b0;
    #1;
    check("p3_drop_no_req", imem_req, 1'b0);
    check("p3_buf_empty", inst_valid, 1'b0);
    tick();                                   // C3: stale response arrives
    check("p3_stale_no_req", imem_req, 1'b0);
    tick();                                   // C4
    check("p3_restart_req", imem_req, 1'b1);
    check("p3_restart_addr", imem_addr, 32'h100);
    repeat (2) tick();                        // C6
    check("p3_still_empty", inst_valid, 1'b0);
    repeat (2) tick();                        // C8
    check("p3_first_valid", inst_valid, 1'b1);
    check("p3_first_pc", inst_pc, 32'h100);
    check("p3_first_inst", inst, 32'h0100_0033);
    tick();                                   // C9
    check("p3_accepts", n_acc, 3);
    check("p3_pops", n_pop, 1);
    do_reset();

    // Redirect coinciding with a response and a consume request.
    expect_stream(32'h0);
    rst = 1'b0; imem_ready = 1'b1; inst_ready = 1'b0;
    repeat (3) tick();                        // C3: head pc 0 valid, rvalid for 0x4
    check("p4_head_before", inst_pc, 32'h0);
    expect_stream(32'h200);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    check("p4_req_low_redirect", imem_req, 1'b0);
    tick();                                   // C4
    redirect = 1'b0;
    #1;
    check("p4_flushed", inst_valid, 1'b0);
    check("p4_restart_addr", imem_addr, 32'h200);
    check("p4_restart_req", imem_req, 1'b1);
    repeat (2) tick();                        // C6
    check("p4_first_pc", inst_pc, 32'h200);
    tick();                                   // C7
    check("p4_accepts", n_acc, 4);
    check("p4_pops", n_pop, 1);
    imem_ready = 1'b0;
    repeat (4) tick();
    check("end_drained", inst_valid, 1'b0);
    check("wrap_progress", w_n_acc >= 3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
